// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory responder: word width,
// M-bus bit positions, responder state encoding and request decode.
package cpu_pkg;

  localparam int WORD_W = 32;

  // EX/MEM M-bus bit positions
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;

  // Responder FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_BUSY = 2'd1;
  localparam logic [1:0] DMEM_DONE = 2'd2;

  // Decoded request kind. A store always wins over a load; 'both' marks the
  // case where a load was also requested so its result is returned as zero.
  typedef struct packed {
    logic wr;
    logic rd_only;
    logic both;
    logic mis;
  } dmem_op_t;

  // m is the 2-bit M-bus, lsb the low byte-address bits (zero when the
  // alignment check is not built in).
  function automatic dmem_op_t decode_op(input logic [1:0] m, input logic [1:0] lsb);
    dmem_op_t op;
    op.wr      = m[MEM_WRITE_BIT];
    op.rd_only = m[MEM_READ_BIT] & ~m[MEM_WRITE_BIT];
    op.both    = m[MEM_READ_BIT] & m[MEM_WRITE_BIT];
    op.mis     = (lsb != 2'b00);
    return op;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM for the data-memory responder: synchronous write, registered read.
// The read register only changes when re_i is high, so it holds the last
// loaded word between reads. Contents are not reset.
module dmem_array import cpu_pkg::*; #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store path: commit the word on the write strobe
  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  // Load path: capture the addressed word on the read strobe
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[idx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
//
// Handshake: a request is any cycle with memread_i|memwrite_i high. While
// stall_o is high the requester must hold memread_i/memwrite_i/addr_i/wdata_i
// stable; the request is captured once, in the IDLE cycle it is first seen.
// Completion is the single cycle with ack_o=1 (stall_o is low there so the
// pipeline advances); rdata_o is valid in that cycle for loads. A request
// present in the cycle after ack_o is accepted immediately.
//
// Optional build macro DMEM_ALIGN_CHECK_EN adds err_o: a misaligned access
// still takes LATENCY cycles but completes with err_o=1, no memory write and
// rdata_o=0.
module dmem_responder import cpu_pkg::*; #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        busy_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam logic       LAT_ONE = (LATENCY == 1);

  logic [1:0]        m_bus;
  logic              req;
  logic [1:0]        addr_lsb;
  logic              unused_addr;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        count;

  dmem_op_t          in_op;
  dmem_op_t          req_op_q;
  dmem_op_t          cur_op;
  logic [ADDR_W-1:0] req_idx_q;
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]       req_wdata_q;
  logic [31:0]       cur_wdata;

  logic              enter_done;
  logic              blocked;
  logic              arr_we;
  logic              arr_re;
  logic [31:0]       arr_rdata;
  logic              rd_zero_q;

  assign m_bus[MEM_READ_BIT]  = memread_i;
  assign m_bus[MEM_WRITE_BIT] = memwrite_i;
  assign req                  = |m_bus;

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_lsb = addr_i[1:0];
`else
  assign addr_lsb = 2'b00;
`endif

  // Upper address bits wrap by design; byte-lane bits only matter for the
  // alignment check.
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  assign in_op = decode_op(m_bus, addr_lsb);

  // In IDLE the access is described by the live inputs (needed when the FSM
  // jumps straight to DONE); afterwards by the captured request.
  assign cur_op    = (state == DMEM_IDLE) ? in_op : req_op_q;
  assign cur_idx   = (state == DMEM_IDLE) ? addr_i[ADDR_W+1:2] : req_idx_q;
  assign cur_wdata = (state == DMEM_IDLE) ? wdata_i : req_wdata_q;

  // Next-state logic for the IDLE -> BUSY -> DONE sequence
  always_comb begin
    state_nxt = state;
    case (state)
      DMEM_IDLE: if (req) state_nxt = LAT_ONE ? DMEM_DONE : DMEM_BUSY;
      DMEM_BUSY: if (count == 4'd1) state_nxt = DMEM_DONE;
      DMEM_DONE: state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  // Memory is touched only on the edge that enters DONE, so an aborted
  // access never reaches the array.
  assign enter_done = (state_nxt == DMEM_DONE) && (state != DMEM_DONE);
  assign blocked    = cur_op.mis;
  assign arr_we     = enter_done & cur_op.wr & ~blocked;
  assign arr_re     = enter_done & cur_op.rd_only & ~blocked;

  // State register and latency counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= DMEM_IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        DMEM_IDLE: if (req) count <= LAT_ONE ? 4'd0 : LAT_M1;
        DMEM_BUSY: count <= count - 4'd1;
        default:   count <= 4'd0;
      endcase
    end
  end

  // Capture the request once, at acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_op_q    <= '0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
    end else if (state == DMEM_IDLE && req) begin
      req_op_q    <= in_op;
      req_idx_q   <= addr_i[ADDR_W+1:2];
      req_wdata_q <= wdata_i;
    end
  end

  // Masks the RAM read register: zero after reset and for accesses that
  // return no data (load+store, misaligned); a plain store leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_zero_q <= 1'b1;
    end else if (enter_done) begin
      if (cur_op.both | blocked)  rd_zero_q <= 1'b1;
      else if (cur_op.rd_only)    rd_zero_q <= 1'b0;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Error flag is high only in the DONE cycle of a misaligned access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= enter_done & blocked;
  end
`endif

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (arr_rdata)
  );

  assign rdata_o = rd_zero_q ? 32'd0 : arr_rdata;
  assign ack_o   = (state == DMEM_DONE);
  assign busy_o  = (state != DMEM_IDLE);
  assign stall_o = req & (state != DMEM_DONE) & ~rst_i;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=3, instance 1 LATENCY=1.
// Table-driven transactions plus hand-written reset/idle sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        memread  [2];
  logic        memwrite [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        stall    [2];
  logic        ack      [2];
  logic        busy     [2];
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err      [2];
`endif

  int lat_cfg [2] = '{3, 1};
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs [11];

  // clock / reset block
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst[0]), .memread_i(memread[0]), .memwrite_i(memwrite[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .stall_o(stall[0]),
    .ack_o(ack[0]), .busy_o(busy[0])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err[0])
`endif
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .memread_i(memread[1]), .memwrite_i(memwrite[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .stall_o(stall[1]),
    .ack_o(ack[1]), .busy_o(busy[1])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver + scoreboard: push expected rdata when driving, pop at ack.
  // Called at #1 after a rising edge with the responder idle.
  task automatic xact(input int w, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int cyc;
    int stalls;
    logic [31:0] e;
    exp_q.push_back(exp_rd);
    memread[w]  = rd;
    memwrite[w] = wr;
    addr[w]     = a;
    wdata[w]    = d;
    #1;
    cyc    = 0;
    stalls = 0;
    while (ack[w] !== 1'b1 && cyc < 40) begin
      if (stall[w] === 1'b1) stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    e = exp_q.pop_front();
    if (ack[w] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ack after %0d cycles", tag, cyc);
    end else begin
      check({tag, " latency"}, cyc, lat_cfg[w]);
      check({tag, " stalls"}, stalls, lat_cfg[w]);
      check({tag, " stall_at_ack"}, {31'd0, stall[w]}, 32'd0);
      check({tag, " rdata"}, rdata[w], e);
`ifdef DMEM_ALIGN_CHECK_EN
      check({tag, " err"}, {31'd0, err[w]}, {31'd0, exp_err});
`else
      if (exp_err) $display("note: %s expects err, check not built in", tag);
`endif
    end
    @(posedge clk); #1;
    check({tag, " ack_pulse"}, {31'd0, ack[w]}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, " err_clear"}, {31'd0, err[w]}, 32'd0);
`endif
    memread[w]  = 1'b0;
    memwrite[w] = 1'b0;
  endtask

  initial begin
    logic [31:0] word1_exp;
    logic [31:0] w8_rdata;
    logic        w6_err;

`ifdef DMEM_ALIGN_CHECK_EN
    word1_exp = 32'h0000_1234;   // misaligned store to 0x6 is dropped
    w8_rdata  = 32'h0;           // misaligned access returns zero
    w6_err    = 1'b1;
`else
    word1_exp = 32'h0000_ABCD;   // 0x6 maps to word 1
    w8_rdata  = 32'h0000_0077;   // plain store keeps previous load data
    w6_err    = 1'b0;
`endif

    //          rd    wr    addr          wdata         exp_rdata     err     name
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,        1'b0,   "wr_08"};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0,  "rd_08"};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_0055, 32'hDEAD_BEEF, 1'b0,  "wr_80_wrap"};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0055, 1'b0,  "rd_00_wrap"};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0077, 32'h0,        1'b0,   "rw_10_prio"};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0077, 1'b0,  "rd_10"};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_1234, 32'h0000_0077, 1'b0,  "wr_04"};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0006, 32'h0000_ABCD, w8_rdata,     w6_err, "wr_06_mis"};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         word1_exp,    1'b0,   "rd_04"};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FF08, 32'h0,         32'hDEAD_BEEF, 1'b0,  "rd_upper"};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,         word1_exp,    1'b0,   "rd_84_wrap"};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; memread[i] = 1'b0; memwrite[i] = 1'b0;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // reset then idle: nothing moves for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle0_c%0d", c), {rdata[0][28:0], stall[0], ack[0], busy[0]}, 32'd0);
      check($sformatf("idle1_c%0d", c), {rdata[1][28:0], stall[1], ack[1], busy[1]}, 32'd0);
    end

    // table-driven transactions on LATENCY=3
    for (int i = 0; i < 11; i++)
      xact(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);

    // LATENCY=1: preload then back-to-back reads with no bubble
    xact(1, 1'b0, 1'b1, 32'h0, 32'h11, 32'h0, 1'b0, "l1_wr_00");
    xact(1, 1'b0, 1'b1, 32'h4, 32'h22, 32'h0, 1'b0, "l1_wr_04");
    xact(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h11, 1'b0, "l1_rd_00");
    xact(1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h22, 1'b0, "l1_rd_04");

    // reset in the middle of a store: the store must not commit
    xact(0, 1'b0, 1'b1, 32'hC, 32'h11, word1_exp, 1'b0, "wr_0c_prior");
    memwrite[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h99;
    #1;
    check("rst_mid stall_accept", {31'd0, stall[0]}, 32'd1);
    @(posedge clk); #1;
    check("rst_mid busy_in_busy", {31'd0, busy[0]}, 32'd1);
    rst[0] = 1'b1;
    #1;
    check("rst_mid outputs_drop", {rdata[0][28:0], stall[0], ack[0], busy[0]}, 32'd0);
    @(posedge clk); #1;
    memwrite[0] = 1'b0;
    check("rst_mid held_idle", {rdata[0][28:0], stall[0], ack[0], busy[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(posedge clk); #1;
    xact(0, 1'b1, 1'b0, 32'hC, 32'h0, 32'h11, 1'b0, "rd_0c_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the pipeline's MEM-stage load/store interface.
- Replaces the zero-latency data memory. Accepts one read or write request at a time from the EX/MEM register outputs and holds stall_o high until the access completes after LATENCY cycles.
- Returns read data with a one-cycle ack_o pulse, so the pipeline can freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB while waiting.

Parameters:
- DEPTH, 32, number of 32-bit words stored; power of two.
- ADDR_W, 5, word-index width; log2(DEPTH).
- LATENCY, 3, cycles from request acceptance to ack; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- memread_i  input  1  load request (EX/MEM M[1]).
- memwrite_i  input  1  store request (EX/MEM M[0]).
- addr_i  input  32  byte address (EX/MEM ALU result).
- wdata_i  input  32  store data (EX/MEM forwarded rt).
- rdata_o  output  32  load data; valid when ack_o=1.
- stall_o  output  1  pipeline freeze request.
- ack_o  output  1  one-cycle completion pulse.
- busy_o  output  1  state != IDLE (debug/perf).

Behaviour:
- One clock; reset is asynchronous and active-high on rst_i.
- Reset values: state=IDLE, count=0, rdata_o=0, ack_o=0, busy_o=0; stall_o=0 while rst_i=1. Memory array is not reset.
- Word index = addr_i[ADDR_W+1:2]. Upper bits and addr_i[1:0] are ignored; addresses past DEPTH wrap.
- req = memread_i | memwrite_i. When both are set, the write takes priority and rdata_o=0 at ack.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req, latch op/index/wdata into a request register. Go to BUSY with count=LATENCY-1 if LATENCY>1, else go to DONE.
  - BUSY: decrement count; when count==1, go to DONE.
  - DONE: ack_o=1; go to IDLE.
- stall_o = req & (state!=DONE), combinational. It is high in the acceptance cycle and all BUSY cycles, and low in the DONE cycle.
- Requester holds memread_i/memwrite_i/addr_i/wdata_i stable while stall_o=1. Inputs are sampled only at acceptance; later changes are ignored.
- Latency: request first seen at cycle T gives ack_o=1 at cycle T+LATENCY, with exactly LATENCY stall cycles.
- Read: rdata_o loaded from mem[index] on the edge entering DONE. rdata_o holds its value until the next read completes.
- Write: mem[index] updated on the edge entering DONE. A read issued after ack observes the new data.
- Back-to-back: a request present in the cycle after DONE (pipeline advanced) is accepted as a new request. There are no idle bubbles beyond that.
- No request in IDLE: stall_o=0, ack_o=0, no state change.
- Reset mid-operation: the access is aborted, a pending write is not committed, and the FSM returns to IDLE.
- Counter width: 4 bits.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - adds output err_o (1 bit, reset 0).
  - a request with addr_i[1:0]!=0 still takes LATENCY cycles.
  - in DONE, err_o=1 together with ack_o; memory is not written and rdata_o=0.
  - err_o is cleared in the next cycle.
- Undefined: no err_o port; addr_i[1:0] are ignored as above.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants DMEM_IDLE=2'd0, DMEM_BUSY=2'd1, DMEM_DONE=2'd2.
  - WORD_W=32.
  - M-bus bit positions MEM_READ_BIT=1, MEM_WRITE_BIT=0.
- One sub-module: dmem_array (synchronous-write, registered-read word RAM, parameters DEPTH/ADDR_W, ports clk_i, we_i, re_i, idx_i, wdata_i, rdata_o). The FSM/counter stays in dmem_responder.

Test Plan:
- Reset then idle: rst_i pulse, no request for 10 cycles -> stall_o=0, ack_o=0, busy_o=0, rdata_o=0 throughout.
- Write then read, LATENCY=3:
  - memwrite_i=1, addr_i=0x8, wdata_i=0xDEADBEEF at T -> stall_o high T..T+2, ack_o at T+3.
  - then memread_i=1, addr_i=0x8 -> ack_o at T+7 with rdata_o=0xDEADBEEF.
- LATENCY=1 back-to-back reads of addr 0x0 and 0x4 (preloaded 0x11, 0x22) -> acks on consecutive-plus-one cycles, rdata_o=0x11 then 0x22, stall exactly 1 cycle each.
- Wrap and priority:
  - write 0x55 to addr_i=0x80 (DEPTH=32) -> read of addr 0x0 returns 0x55.
  - memread_i=memwrite_i=1 with wdata 0x77 -> rdata_o=0 at ack, a later read returns 0x77.
- Reset mid-write: memwrite_i to addr 0xC, data 0x99, assert rst_i in BUSY -> stall_o/busy_o drop immediately, a later read of 0xC returns the prior value.
- With DMEM_ALIGN_CHECK_EN: write to addr 0x6 -> err_o=ack_o=1 at T+LATENCY, a read of 0x4 is unchanged; without the macro the same write updates word 1.
